// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the two-port DataMemory arbiter: two requester ports,
// the level-sensitive memory side and the busy status.
interface dmem_arbiter_if #(
    parameter int DW = 32
);
    logic          req0;
    logic          we0;
    logic [31:0]   addr0;
    logic [DW-1:0] wdata0;
    logic          done0;
    logic          err0;
    logic [DW-1:0] rdata0;

    logic          req1;
    logic          we1;
    logic [31:0]   addr1;
    logic [DW-1:0] wdata1;
    logic          done1;
    logic          err1;
    logic [DW-1:0] rdata1;

    logic [31:0]   DAddr;
    logic [DW-1:0] DataIn;
    logic          RD;
    logic          WR;
    logic [DW-1:0] DataOut;
    logic          busy;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  DataOut,
        output done0, err0, rdata0,
        output done1, err1, rdata1,
        output DAddr, DataIn, RD, WR, busy
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output DataOut,
        input  done0, err0, rdata0,
        input  done1, err1, rdata1,
        input  DAddr, DataIn, RD, WR, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving two requesters sequential access to a
// level-sensitive DataMemory through fully registered RD/WR/DAddr/DataIn.
//
// state   | meaning
// IDLE    | waiting for req0/req1; grant latched on the edge a request is seen
// ACCESS  | address/data/enable driven to memory
// CAPTURE | enables held; read data registered at the end of this cycle
// DONE    | enables low, winner's done (and err) pulse for one cycle
module dmem_arbiter #(
    parameter int WORDS = 32,
    parameter int DW    = 32
) (
    input logic           CLK,
    input logic           Reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, DONE} state_t;

    localparam logic [31:0] WORDS_U = WORDS;

    state_t        state;
    logic          last;
    logic          win_id;
    logic          win_we;

    logic          grant_id;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [DW-1:0] sel_wdata;

    // With a tie the port not served last wins; a lone request always wins.
    assign grant_id  = (bus.req0 && bus.req1) ? ~last : bus.req1;
    assign sel_we    = grant_id ? bus.we1    : bus.we0;
    assign sel_addr  = grant_id ? bus.addr1  : bus.addr0;
    assign sel_wdata = grant_id ? bus.wdata1 : bus.wdata0;

    assign bus.busy = (state != IDLE);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            last       <= 1'b1;
            win_id     <= 1'b0;
            win_we     <= 1'b0;
            bus.DAddr  <= '0;
            bus.DataIn <= '0;
            bus.RD     <= 1'b0;
            bus.WR     <= 1'b0;
            bus.done0  <= 1'b0;
            bus.done1  <= 1'b0;
            bus.err0   <= 1'b0;
            bus.err1   <= 1'b0;
            bus.rdata0 <= '0;
            bus.rdata1 <= '0;
        end else begin
            bus.done0 <= 1'b0;
            bus.done1 <= 1'b0;
            bus.err0  <= 1'b0;
            bus.err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        win_id <= grant_id;
                        win_we <= sel_we;
                        last   <= grant_id;
                        // Out-of-range never touches memory: report straight away.
                        if (sel_addr >= WORDS_U) begin
                            state <= DONE;
                            if (grant_id) begin
                                bus.done1  <= 1'b1;
                                bus.err1   <= 1'b1;
                                bus.rdata1 <= {DW{1'b0}};
                            end else begin
                                bus.done0  <= 1'b1;
                                bus.err0   <= 1'b1;
                                bus.rdata0 <= {DW{1'b0}};
                            end
                        end else begin
                            state      <= ACCESS;
                            bus.DAddr  <= sel_addr;
                            bus.DataIn <= sel_wdata;
                            bus.RD     <= ~sel_we;
                            bus.WR     <= sel_we;
                        end
                    end
                end
                ACCESS: state <= CAPTURE;
                CAPTURE: begin
                    state  <= DONE;
                    bus.RD <= 1'b0;
                    bus.WR <= 1'b0;
                    if (win_id) begin
                        bus.done1 <= 1'b1;
                        if (!win_we) bus.rdata1 <= bus.DataOut;
                    end else begin
                        bus.done0 <= 1'b1;
                        if (!win_we) bus.rdata0 <= bus.DataOut;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: table of single accesses against a
// behavioural memory, then contention, reset-abort and req-drop sequences.
module tb_dmem_arbiter;
    logic CLK = 1'b0;
    logic Reset = 1'b1;

    dmem_arbiter_if #(.DW(32)) bus ();

    dmem_arbiter #(.WORDS(32), .DW(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    logic [31:0] mem [32] = '{default: 32'h0};

    always_comb bus.DataOut = bus.RD ? mem[bus.DAddr[4:0]] : 32'h0;
    always @(posedge CLK) if (bus.WR) mem[bus.DAddr[4:0]] <= bus.DataIn;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_rd0 = 32'h0;
    logic [31:0] exp_rd1 = 32'h0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (!Reset) check("rd_wr_exclusive", 64'(bus.RD & bus.WR), 64'(1'b0));
    end

    task automatic drive(input logic port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic do_access(input vec_t v, input string tag);
        logic d, e, od;
        logic [31:0] rd, ord, oexp;
        @(negedge CLK);
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(negedge CLK);
        check({tag, "_busy"}, 64'(bus.busy), 64'(1'b1));
        if (!v.err) begin
            for (int c = 0; c < 2; c++) begin
                d = v.port ? bus.done1 : bus.done0;
                check({tag, "_rdwr"}, 64'({bus.RD, bus.WR}), 64'({~v.we, v.we}));
                check({tag, "_daddr"}, 64'(bus.DAddr), 64'(v.addr));
                check({tag, "_datain"}, 64'(bus.DataIn), 64'(v.wdata));
                check({tag, "_early_done"}, 64'(d), 64'(1'b0));
                if (c == 0) @(negedge CLK);
            end
            @(negedge CLK);
        end
        d   = v.port ? bus.done1  : bus.done0;
        e   = v.port ? bus.err1   : bus.err0;
        rd  = v.port ? bus.rdata1 : bus.rdata0;
        od  = v.port ? bus.done0  : bus.done1;
        ord = v.port ? bus.rdata0 : bus.rdata1;
        oexp = v.port ? exp_rd0 : exp_rd1;
        check({tag, "_done_err"}, 64'({d, e}), 64'({1'b1, v.err}));
        check({tag, "_rdwr_done"}, 64'({bus.RD, bus.WR}), 64'(2'b00));
        check({tag, "_rdata"}, 64'(rd), 64'(v.rdata));
        check({tag, "_other_done"}, 64'(od), 64'(1'b0));
        check({tag, "_other_rdata"}, 64'(ord), 64'(oexp));
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check({tag, "_idle"}, 64'({bus.busy, bus.done0, bus.done1}), 64'(3'b000));
        if (v.port) exp_rd1 = v.rdata; else exp_rd0 = v.rdata;
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{1'b0, 1'b1, 32'd5,          32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b1, 1'b0, 32'd5,          32'h00000000, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b1, 32'd31,         32'h12345678, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b0, 32'd31,         32'h0000AAAA, 1'b0, 32'h12345678};
        vecs[4]  = '{1'b0, 1'b0, 32'd32,         32'h00000000, 1'b1, 32'h00000000};
        vecs[5]  = '{1'b1, 1'b1, 32'd0,          32'hA5A5A5A5, 1'b0, 32'hDEADBEEF};
        vecs[6]  = '{1'b0, 1'b0, 32'd0,          32'h00000000, 1'b0, 32'hA5A5A5A5};
        vecs[7]  = '{1'b1, 1'b0, 32'd40,         32'h00000000, 1'b1, 32'h00000000};
        vecs[8]  = '{1'b1, 1'b0, 32'd31,         32'h00000000, 1'b0, 32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFFFF,   32'h00000001, 1'b1, 32'h00000000};
        vecs[10] = '{1'b1, 1'b1, 32'd7,          32'h0BADF00D, 1'b0, 32'h12345678};
        vecs[11] = '{1'b0, 1'b0, 32'd5,          32'h00000000, 1'b0, 32'hDEADBEEF};

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge CLK);
        check("reset_mem_side", 64'({bus.RD, bus.WR, bus.DAddr, bus.DataIn}), 64'(0));
        check("reset_status", 64'({bus.busy, bus.done0, bus.done1, bus.err0, bus.err1}), 64'(0));
        check("reset_rdata", 64'({bus.rdata0, bus.rdata1}), 64'(0));
        Reset = 1'b0;

        for (int i = 0; i < 12; i++) do_access(vecs[i], $sformatf("v%0d", i));

        // Contention from reset: grants alternate 0,1,0,1 starting with port 0.
        @(negedge CLK);
        Reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'd31, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge CLK);
            check($sformatf("rr_done_c%0d", cyc), 64'({bus.done1, bus.done0}),
                  64'({(cyc == 7 || cyc == 15), (cyc == 3 || cyc == 11)}));
            if (cyc == 3)  check("rr_rdata0", 64'(bus.rdata0), 64'(32'hDEADBEEF));
            if (cyc == 7)  check("rr_rdata1", 64'(bus.rdata1), 64'(32'h12345678));
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset during ACCESS of a write aborts it without a clock.
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        drive(1'b0, 1'b1, 1'b1, 32'd7, 32'h11111111);
        @(negedge CLK);
        check("abort_wr_before", 64'({bus.WR, bus.busy}), 64'(2'b11));
        #2 Reset = 1'b1;
        #1 check("abort_async", 64'({bus.RD, bus.WR, bus.busy}), 64'(3'b000));
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            check("abort_no_done", 64'({bus.done0, bus.busy}), 64'(2'b00));
        end
        v = '{1'b0, 1'b0, 32'd7, 32'h0, 1'b0, 32'h0BADF00D};
        do_access(v, "post_abort");

        // req1 dropped during CAPTURE still completes.
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 32'd0, 32'h0);
        @(negedge CLK);
        check("drop_access", 64'(bus.RD), 64'(1'b1));
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        check("drop_done1", 64'(bus.done1), 64'(1'b1));
        check("drop_rdata1", 64'(bus.rdata1), 64'(32'hA5A5A5A5));
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check("drop_idle", 64'({bus.busy, bus.done1}), 64'(2'b00));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WORDS, default 32, giving the number of addressable 32-bit words in DataMemory (128 bytes / 4).
REQ-002 The block SHALL have parameter DW, default 32, giving the data width of all data ports.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports CLK (input, 1, rising-edge clock) and Reset (input, 1, asynchronous active-high reset).
REQ-004 Port 0 (CPU load/store unit) SHALL have these ports:
- req0 (input, 1): access request.
- we0 (input, 1): 1 = write, 0 = read.
- addr0 (input, 32): word index.
- wdata0 (input, DW): write data.
- done0 (output, 1): one-cycle completion pulse.
- err0 (output, 1): out-of-range flag, valid with done0.
- rdata0 (output, DW): read data, valid with done0.
REQ-005 Port 1 (debug/DMA loader) SHALL have ports req1, we1, addr1, wdata1, done1, err1 and rdata1, with the same directions, widths and meanings as port 0.
REQ-006 The memory side SHALL have these ports:
- DAddr (output, 32): word index to DataMemory.
- DataIn (output, DW): write data to DataMemory.
- RD (output, 1): read enable.
- WR (output, 1): write enable.
- DataOut (input, DW): read data from DataMemory.
REQ-007 The block SHALL have output busy (1), high whenever the FSM is not in IDLE.

Function
REQ-008 The FSM SHALL have exactly four states: IDLE, ACCESS, CAPTURE and DONE.
REQ-009 In IDLE, at a rising edge with req0 or req1 high, the block SHALL:
- latch the winning port's id, we, addr and wdata;
- move to ACCESS.
REQ-010 With no request in IDLE, the FSM SHALL remain in IDLE.
REQ-011 Arbitration SHALL be round-robin:
- with both requests high, the port not served last wins;
- with only one request high, that port wins regardless of the pointer.
REQ-012 The last-served pointer SHALL update only when a grant is latched, including grants that end in err.
REQ-013 In ACCESS, DAddr SHALL equal the latched addr and DataIn SHALL equal the latched wdata, with RD = ~we and WR = we.
REQ-014 The next state after ACCESS SHALL be CAPTURE.
REQ-015 In CAPTURE, DAddr, DataIn, RD and WR SHALL be held unchanged.
REQ-016 At the end of CAPTURE, for a read, DataOut SHALL be registered into the winner's rdata; the next state SHALL be DONE.
REQ-017 In DONE:
- RD and WR SHALL be 0;
- the winner's done SHALL be high for exactly this one cycle;
- the next state SHALL be IDLE.
REQ-018 Access latency SHALL be 3 cycles from the granting edge to done, and back-to-back accesses SHALL complete at most once every 4 cycles.
REQ-019 If the latched addr is >= WORDS:
- the FSM SHALL go IDLE -> DONE directly;
- RD and WR SHALL never assert;
- err and done SHALL pulse together and rdata SHALL be 0.
REQ-020 For writes, rdata SHALL keep its previous value.
REQ-021 The non-winning port's done, err and rdata SHALL not change during another port's access.
REQ-022 A requester SHALL hold req until its done.
REQ-023 If req drops mid-access, the access SHALL still complete and done SHALL still pulse.
REQ-024 A req still high in the DONE cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-025 RD and WR SHALL never be high simultaneously.
REQ-026 RD, WR, DAddr and DataIn SHALL change only on the clock edge (registered), giving glitch-free enables to the level-sensitive memory.
REQ-027 busy SHALL be 0 in IDLE and 1 in ACCESS, CAPTURE and DONE.

Reset
REQ-028 Reset high SHALL asynchronously force:
- FSM = IDLE;
- pointer = port 1 served last, so port 0 wins the first tie;
- RD = WR = 0, DAddr = 0, DataIn = 0;
- done0/1 = 0, err0/1 = 0, rdata0/1 = 0, busy = 0.
REQ-029 Reset asserted mid-access SHALL abort the access immediately with no done pulse, and RD/WR SHALL drop without waiting for a clock.
REQ-030 After Reset deasserts, the first grant SHALL occur at the first rising edge with a request present.

Verification
REQ-031 Port-0 write: addr0 = 5, wdata0 = 0xDEADBEEF, we0 = 1 -> WR high for 2 cycles with DAddr = 5; done0 pulses 3 cycles after grant; err0 = 0.
REQ-032 Port-1 read-back: addr1 = 5, we1 = 0 -> RD high for 2 cycles; rdata1 = 0xDEADBEEF with done1; rdata0 unchanged.
REQ-033 Contention: req0 and req1 held high from reset -> grants alternate 0,1,0,1, with done pulses every 4 cycles.
REQ-034 Out-of-range: addr0 = 32 -> RD = WR = 0 throughout; done0 and err0 pulse 1 cycle after grant; rdata0 = 0.
REQ-035 Reset mid-ACCESS on a write -> WR drops asynchronously; no done; busy = 0; the next req0 is granted normally.
REQ-036 req1 dropped during CAPTURE -> done1 still pulses; the FSM returns to IDLE.
